// File: rtl/mips_defs.sv
// ============================================================================
// mips_defs: widths and constants shared by the register file and its ports.
// Revision: 1.0
// ============================================================================
`default_nettype none

package mips_defs;
  localparam int          WORD_W       = 32;
  localparam int          REG_ADDR_W   = 5;
  localparam int          REG_COUNT    = 1 << REG_ADDR_W;
  localparam int          ZERO_REG     = 0;
  localparam logic [31:0] WR_COUNT_MAX = 32'hFFFF_FFFF;
endpackage

`default_nettype wire

// File: rtl/register_file_reg_read_port.sv
// ============================================================================
// reg_read_port: one decode read port with zero-register check and
// write-first bypass from the write-back stage.
// Revision: 1.0
// ============================================================================
`default_nettype none

module reg_read_port #(
  parameter int WORD_W = mips_defs::WORD_W,
  parameter int ADDR_W = mips_defs::REG_ADDR_W
) (
  input  logic              i_rst,
  input  logic [ADDR_W-1:0] i_src,
  input  logic              i_wb_en,
  input  logic [ADDR_W-1:0] i_wb_dest,
  input  logic [WORD_W-1:0] i_wb_value,
  input  logic [WORD_W-1:0] i_stored,
  output logic [WORD_W-1:0] o_data
);

  logic w_is_zero;
  logic w_bypass_hit;

  assign w_is_zero    = (i_src == ADDR_W'(mips_defs::ZERO_REG));
  assign w_bypass_hit = i_wb_en && (i_wb_dest == i_src);

  always_comb begin
    o_data = i_stored;
    if (i_rst || w_is_zero) begin
      o_data = '0;
    end else if (w_bypass_hit) begin
      o_data = i_wb_value;
    end
  end

endmodule

`default_nettype wire

// File: rtl/register_file.sv
// ============================================================================
// register_file: MIPS architectural register file, two bypassed read ports,
// one write-back port, debug read port and saturating commit counter.
// Revision: 1.0
// ============================================================================
`default_nettype none

module register_file #(
  parameter int WORD_W = mips_defs::WORD_W,
  parameter int ADDR_W = mips_defs::REG_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] src1,
  input  logic [ADDR_W-1:0] src2,
  output logic [WORD_W-1:0] Reg1,
  output logic [WORD_W-1:0] Reg2,
  input  logic              WB_en,
  input  logic [ADDR_W-1:0] WB_dest,
  input  logic [WORD_W-1:0] WB_Value,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [WORD_W-1:0] dbg_data,
  output logic [31:0]       wr_count
);

  localparam int C_REG_COUNT = 1 << ADDR_W;

  logic [WORD_W-1:0] regs_q [C_REG_COUNT];
  logic [WORD_W-1:0] regs_d [C_REG_COUNT];
  logic [31:0]       wr_count_q;
  logic [31:0]       wr_count_d;
  logic              w_commit;

  assign w_commit = WB_en && !rst && (WB_dest != ADDR_W'(mips_defs::ZERO_REG));

  always_comb begin
    regs_d = regs_q;
    if (rst) begin
      for (int i = 0; i < C_REG_COUNT; i++) begin
        regs_d[i] = '0;
      end
    end else if (w_commit) begin
      regs_d[WB_dest] = WB_Value;
    end
  end

  always_comb begin
    wr_count_d = wr_count_q;
    if (rst) begin
      wr_count_d = '0;
    end else if (w_commit && (wr_count_q != mips_defs::WR_COUNT_MAX)) begin
      wr_count_d = wr_count_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    regs_q     <= regs_d;
    wr_count_q <= wr_count_d;
  end

  reg_read_port #(.WORD_W(WORD_W), .ADDR_W(ADDR_W)) u_port1 (
    .i_rst      (rst),
    .i_src      (src1),
    .i_wb_en    (WB_en),
    .i_wb_dest  (WB_dest),
    .i_wb_value (WB_Value),
    .i_stored   (regs_q[src1]),
    .o_data     (Reg1)
  );

  reg_read_port #(.WORD_W(WORD_W), .ADDR_W(ADDR_W)) u_port2 (
    .i_rst      (rst),
    .i_src      (src2),
    .i_wb_en    (WB_en),
    .i_wb_dest  (WB_dest),
    .i_wb_value (WB_Value),
    .i_stored   (regs_q[src2]),
    .o_data     (Reg2)
  );

  // Debug view is storage only; reads as zero while reset is held.
  assign dbg_data = (rst || dbg_addr == ADDR_W'(mips_defs::ZERO_REG)) ? '0 : regs_q[dbg_addr];
  assign wr_count = rst ? 32'd0 : wr_count_q;

endmodule

`default_nettype wire

// File: tb/tb_register_file.sv
// ============================================================================
// tb_register_file: vector table plus scoreboard queue for register_file.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_register_file;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  src1, src2, WB_dest, dbg_addr;
  logic [31:0] Reg1, Reg2, WB_Value, dbg_data, wr_count;
  logic        WB_en;

  always #5 clk = ~clk;

  register_file #(.WORD_W(32), .ADDR_W(5)) dut (
    .clk      (clk),
    .rst      (rst),
    .src1     (src1),
    .src2     (src2),
    .Reg1     (Reg1),
    .Reg2     (Reg2),
    .WB_en    (WB_en),
    .WB_dest  (WB_dest),
    .WB_Value (WB_Value),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data),
    .wr_count (wr_count)
  );

  typedef struct {
    logic        rst;
    logic        en;
    logic [4:0]  dest;
    logic [31:0] val;
    logic [4:0]  s1;
    logic [4:0]  s2;
    logic [4:0]  dbg;
    logic [31:0] e1;
    logic [31:0] e2;
    logic [31:0] ed;
    logic [31:0] ec;
  } vec_t;

  typedef struct {
    string       tag;
    logic [31:0] e1;
    logic [31:0] e2;
    logic [31:0] ed;
    logic [31:0] ec;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  function automatic vec_t mk(logic r, logic en, logic [4:0] dest, logic [31:0] val,
                              logic [4:0] s1, logic [4:0] s2, logic [4:0] dbg,
                              logic [31:0] e1, logic [31:0] e2, logic [31:0] ed,
                              logic [31:0] ec);
    vec_t v;
    v.rst = r;  v.en = en; v.dest = dest; v.val = val;
    v.s1 = s1;  v.s2 = s2; v.dbg = dbg;
    v.e1 = e1;  v.e2 = e2; v.ed = ed; v.ec = ec;
    return v;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(vec_t v, string tag);
    exp_t e;
    @(negedge clk);
    rst = v.rst; WB_en = v.en; WB_dest = v.dest; WB_Value = v.val;
    src1 = v.s1; src2 = v.s2; dbg_addr = v.dbg;
    e.tag = tag; e.e1 = v.e1; e.e2 = v.e2; e.ed = v.ed; e.ec = v.ec;
    sb.push_back(e);
  endtask

  task automatic sample();
    exp_t e;
    #1;
    if (sb.size() == 0) begin
      check("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      check({e.tag, ".Reg1"},     Reg1,     e.e1);
      check({e.tag, ".Reg2"},     Reg2,     e.e2);
      check({e.tag, ".dbg_data"}, dbg_data, e.ed);
      check({e.tag, ".wr_count"}, wr_count, e.ec);
    end
  endtask

  task automatic apply(vec_t v, string tag);
    drive(v, tag);
    sample();
  endtask

  vec_t tbl[14];

  initial begin
    rst = 1'b1; WB_en = 1'b0; WB_dest = '0; WB_Value = '0;
    src1 = '0; src2 = '0; dbg_addr = '0;

    //            rst en dest val            s1 s2 dbg  Reg1          Reg2          dbg           count
    tbl[0]  = mk(1, 1, 7, 32'h0000_000A,   7, 7, 7,  32'h0,        32'h0,        32'h0,        32'd0);
    tbl[1]  = mk(0, 0, 0, 32'h0,           7, 0, 7,  32'h0,        32'h0,        32'h0,        32'd0);
    tbl[2]  = mk(0, 1, 5, 32'hDEAD_BEEF,   5, 5, 5,  32'hDEAD_BEEF,32'hDEAD_BEEF,32'h0,        32'd0);
    tbl[3]  = mk(0, 0, 0, 32'h0,           5, 0, 5,  32'hDEAD_BEEF,32'h0,        32'hDEAD_BEEF,32'd1);
    tbl[4]  = mk(0, 1, 0, 32'h0000_1234,   0, 0, 0,  32'h0,        32'h0,        32'h0,        32'd1);
    tbl[5]  = mk(0, 0, 0, 32'h0,           0, 0, 0,  32'h0,        32'h0,        32'h0,        32'd1);
    tbl[6]  = mk(0, 1, 3, 32'h0000_0001,   3, 5, 3,  32'h1,        32'hDEAD_BEEF,32'h0,        32'd1);
    tbl[7]  = mk(0, 1, 3, 32'h0000_0002,   3, 3, 3,  32'h2,        32'h2,        32'h1,        32'd2);
    tbl[8]  = mk(0, 0, 0, 32'h0,           3, 5, 3,  32'h2,        32'hDEAD_BEEF,32'h2,        32'd3);
    tbl[9]  = mk(0, 1, 9, 32'h0000_0055,   8, 9, 9,  32'h0,        32'h55,       32'h0,        32'd3);
    tbl[10] = mk(0, 1, 0, 32'h0000_FFFF,   9, 0, 9,  32'h55,       32'h0,        32'h55,       32'd4);
    tbl[11] = mk(1, 1, 3, 32'h0000_0077,   3, 5, 3,  32'h0,        32'h0,        32'h0,        32'd0);
    tbl[12] = mk(0, 1, 3, 32'h0000_0088,   3, 5, 3,  32'h88,       32'h0,        32'h0,        32'd0);
    tbl[13] = mk(0, 0, 0, 32'h0,           3, 9, 3,  32'h88,       32'h0,        32'h88,       32'd1);

    apply(mk(1, 0, 0, 32'h0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 32'd0), "reset_hold");

    for (int i = 0; i < 2; i++) apply(tbl[i], $sformatf("row%0d", i));

    // Every index on every port must read zero after reset.
    for (int i = 0; i < 32; i++) begin
      apply(mk(0, 0, 0, 32'h0, 5'(i), 5'(31 - i), 5'(i), 32'h0, 32'h0, 32'h0, 32'd0),
            $sformatf("sweep%0d", i));
    end

    for (int i = 2; i < 14; i++) apply(tbl[i], $sformatf("row%0d", i));

    // Saturation: preload the counter just below its ceiling.
    @(negedge clk);
    rst = 1'b0; WB_en = 1'b0;
    force dut.wr_count_q = 32'hFFFF_FFFE;
    #1;
    release dut.wr_count_q;
    #1;
    check("sat_preload", wr_count, 32'hFFFF_FFFE);
    apply(mk(0, 1, 10, 32'h10, 10, 0, 10, 32'h10, 32'h0, 32'h0,  32'hFFFF_FFFE), "sat0");
    apply(mk(0, 1, 11, 32'h11, 10, 11, 10, 32'h10, 32'h11, 32'h10, 32'hFFFF_FFFF), "sat1");
    apply(mk(0, 1, 12, 32'h12, 11, 12, 11, 32'h11, 32'h12, 32'h11, 32'hFFFF_FFFF), "sat2");
    apply(mk(0, 0, 0,  32'h0,  12, 10, 12, 32'h12, 32'h10, 32'h12, 32'hFFFF_FFFF), "sat3");

    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
